// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
//   CNT_W_DFLT       : default counter / terminal-count width
//   DEFAULT_MAX_DFLT : default terminal count loaded at reset
//   cnt_t            : counter type at the default width
package clk_div_pkg;

  localparam int unsigned CNT_W_DFLT       = 24;
  localparam int unsigned DEFAULT_MAX_DFLT = 0;

  typedef logic [CNT_W_DFLT-1:0] cnt_t;

endpackage

// File: rtl/clk_div_multi_ch.sv
// One divider channel: a counter that runs from 0 to a loadable terminal count,
// toggling a divided clock on each terminal hit and emitting registered strobes.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   en       : count enable
//   load     : capture max_in as the new terminal count and restart the count
//   max_in   : terminal count presented for load
//   sclk     : registered divided clock (50% duty)
//   tick     : 1-cycle strobe in the cycle sclk changes
//   rise     : 1-cycle strobe in the cycle sclk goes 0->1
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned       CNT_W       = CNT_W_DFLT,
  parameter logic [CNT_W-1:0]  DEFAULT_MAX = CNT_W'(DEFAULT_MAX_DFLT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] max_in,
  output logic             sclk,
  output logic             tick,
  output logic             rise
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             sclk_q, sclk_d;
  logic             tick_q, tick_d;
  logic             rise_q, rise_d;

  always_comb begin
    cnt_d  = cnt_q;
    max_d  = max_q;
    sclk_d = sclk_q;
    tick_d = 1'b0;
    rise_d = 1'b0;
    if (load) begin
      // Load wins over en; clearing the count keeps cnt_q <= max_q always.
      max_d = max_in;
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == max_q) begin
        sclk_d = ~sclk_q;
        cnt_d  = '0;
        tick_d = 1'b1;
        rise_d = ~sclk_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      max_q  <= DEFAULT_MAX;
      sclk_q <= 1'b0;
      tick_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      max_q  <= max_d;
      sclk_q <= sclk_d;
      tick_q <= tick_d;
      rise_q <= rise_d;
    end
  end

  assign sclk = sclk_q;
  assign tick = tick_q;
  assign rise = rise_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable divided-clock / clock-enable generator.
// Each channel has an independent runtime-loadable terminal count.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   en       : per-channel count enable
//   load     : per-channel terminal-count capture strobe
//   max_cnt  : packed terminal counts, channel i at [i*CNT_W +: CNT_W]
//   sclk     : per-channel divided clock (registered)
//   tick     : per-channel strobe, high in the cycle sclk changes
//   rise     : per-channel strobe, high in the cycle sclk goes 0->1
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned       NUM_CH      = 2,
  parameter int unsigned       CNT_W       = CNT_W_DFLT,
  parameter logic [CNT_W-1:0]  DEFAULT_MAX = CNT_W'(DEFAULT_MAX_DFLT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*CNT_W-1:0] max_cnt,
  output logic [NUM_CH-1:0]       sclk,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       rise
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_MAX (DEFAULT_MAX)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en[g]),
      .load   (load[g]),
      .max_in (max_cnt[g*CNT_W +: CNT_W]),
      .sclk   (sclk[g]),
      .tick   (tick[g]),
      .rise   (rise[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned DMAX   = 0;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*CNT_W-1:0] max_cnt;
  logic [NUM_CH-1:0]       sclk;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       rise;

  clk_div_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_MAX (CNT_W'(DMAX))
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .max_cnt (max_cnt),
    .sclk    (sclk),
    .tick    (tick),
    .rise    (rise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] sclk;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] rise;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic done  = 1'b0;

  // Reference model: per channel, the number of enabled cycles since the last
  // reset/load, the sclk level at that restart, and the terminal count.
  // sclk level = base XOR parity of completed half-periods of (max+1) cycles.
  int unsigned n_en [NUM_CH];
  logic        base [NUM_CH];
  int unsigned mx   [NUM_CH];

  function automatic logic model_sclk(input int unsigned ch);
    return base[ch] ^ logic'((n_en[ch] / (mx[ch] + 1)) % 2);
  endfunction

  task automatic step(input logic r, input logic [NUM_CH-1:0] e,
                      input logic [NUM_CH-1:0] l, input int unsigned m0,
                      input int unsigned m1);
    logic [NUM_CH*CNT_W-1:0] mc;
    exp_t x;
    mc = '0;
    mc[0 +: CNT_W]     = CNT_W'(m0);
    mc[CNT_W +: CNT_W] = CNT_W'(m1);
    @(negedge clk);
    rst = r; en = e; load = l; max_cnt = mc;
    @(posedge clk);
    x = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r) begin
        n_en[i] = 0; base[i] = 1'b0; mx[i] = DMAX;
      end else if (l[i]) begin
        base[i] = model_sclk(i);
        n_en[i] = 0;
        mx[i]   = (i == 0) ? m0 : m1;
      end else if (e[i]) begin
        n_en[i]++;
        if (n_en[i] % (mx[i] + 1) == 0) x.tick[i] = 1'b1;
      end
      x.sclk[i] = model_sclk(i);
      x.rise[i] = x.tick[i] & x.sclk[i];
    end
    exp_q.push_back(x);
  endtask

  task automatic run(input int unsigned cycles, input logic [NUM_CH-1:0] e);
    for (int k = 0; k < int'(cycles); k++) step(1'b0, e, '0, 0, 0);
  endtask

  // Monitor: outputs are registered and valid every cycle after an edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        tests++;
        if (sclk !== x.sclk) begin
          fails++;
          $display("FAIL sclk t=%0t got=%b want=%b", $time, sclk, x.sclk);
        end
        tests++;
        if (tick !== x.tick) begin
          fails++;
          $display("FAIL tick t=%0t got=%b want=%b", $time, tick, x.tick);
        end
        tests++;
        if (rise !== x.rise) begin
          fails++;
          $display("FAIL rise t=%0t got=%b want=%b", $time, rise, x.rise);
        end
      end
    end
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout t=%0t got=running want=finished", $time);
      $fatal(1, "timeout");
    end
  end

  initial begin
    rst = 1'b1; en = '0; load = '0; max_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n_en[i] = 0; base[i] = 1'b0; mx[i] = DMAX;
    end

    // Reset with en asserted, then default max=0 runs at clk/2.
    step(1'b1, 2'b11, 2'b00, 0, 0);
    step(1'b1, 2'b11, 2'b00, 0, 0);
    run(8, 2'b11);

    // Channel 0 max=3 alone.
    step(1'b0, 2'b01, 2'b01, 3, 0);
    run(16, 2'b01);

    // Independent periods: ch0 max=1, ch1 max=4.
    step(1'b0, 2'b11, 2'b11, 1, 4);
    run(30, 2'b11);

    // Pause at mid-count then resume.
    step(1'b0, 2'b00, 2'b01, 3, 0);
    run(2, 2'b01);
    run(5, 2'b00);
    run(4, 2'b01);

    // Reload mid-count with en asserted in the same cycle.
    step(1'b0, 2'b00, 2'b01, 9, 0);
    run(5, 2'b01);
    step(1'b0, 2'b01, 2'b01, 1, 0);
    run(6, 2'b01);

    // Reset while sclk high, with load and en the same cycle.
    step(1'b0, 2'b00, 2'b11, 1, 1);
    run(2, 2'b11);
    step(1'b1, 2'b11, 2'b11, 5, 5);
    run(6, 2'b11);

    // Full-range terminal count.
    step(1'b0, 2'b00, 2'b11, (1 << CNT_W) - 1, 0);
    run(140, 2'b11);

    // Random traffic.
    for (int k = 0; k < 800; k++) begin
      logic                r;
      logic [NUM_CH-1:0]   e;
      logic [NUM_CH-1:0]   l;
      int unsigned         m0;
      int unsigned         m1;
      r  = ($urandom_range(0, 63) == 0);
      e  = '0;
      l  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        e[i] = ($urandom_range(0, 3) != 0);
        l[i] = ($urandom_range(0, 15) == 0);
      end
      m0 = ($urandom_range(0, 7) == 0) ? (1 << CNT_W) - 1 : $urandom_range(0, 7);
      m1 = $urandom_range(0, 9);
      step(r, e, l, m0, m1);
    end

    @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
